// File: rtl/wb_initiator_pkg.sv
// wb_initiator_pkg: FSM state encoding and command length width for wb_initiator
package wb_initiator_pkg;
  typedef enum logic [1:0] {IDLE, STROBE, GAP, RESP} state_e;
  localparam int LEN_W = 4;
endpackage

// File: rtl/wb_initiator.sv
// wb_initiator: valid/ready command stream -> Wishbone classic single/burst accesses, one response per beat, per-beat ack timeout
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_reset_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [DW-1:0]     cmd_dat_i,
  input  logic              cmd_we_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic              rsp_err_o,
  output logic              rsp_last_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [DW/8-1:0]   wb_sel_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  output logic              busy_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e           state_q;
  logic [AW-1:0]    adr_q;
  logic [DW-1:0]    dat_q, rsp_dat_q;
  logic [DW/8-1:0]  sel_q;
  logic [LEN_W-1:0] len_q;
  logic [TW-1:0]    tmo_q;
  logic             we_q, cyc_q, stb_q, rsp_valid_q, rsp_err_q, rsp_last_q, cmd_ready_q, busy_q;
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      len_q       <= '0;
      tmo_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          adr_q       <= cmd_adr_i;
          dat_q       <= cmd_dat_i;
          sel_q       <= cmd_sel_i;
          we_q        <= cmd_we_i;
          len_q       <= cmd_len_i;
          tmo_q       <= '0;
          cyc_q       <= 1'b1;
          stb_q       <= 1'b1;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          state_q     <= STROBE;
        end
        STROBE: if (wb_ack_i) begin
          stb_q       <= 1'b0;
          cyc_q       <= len_q != '0;
          rsp_valid_q <= 1'b1;
          rsp_dat_q   <= we_q ? '0 : wb_dat_i;
          rsp_err_q   <= 1'b0;
          rsp_last_q  <= len_q == '0;
          state_q     <= RESP;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          stb_q       <= 1'b0;
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_dat_q   <= '0;
          rsp_err_q   <= 1'b1;
          rsp_last_q  <= 1'b1;
          state_q     <= RESP;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          if (rsp_last_q) begin
            cyc_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            adr_q   <= adr_q + AW'(1);
            len_q   <= len_q - LEN_W'(1);
            state_q <= GAP;
          end
        end
        GAP: begin
          stb_q   <= 1'b1;
          tmo_q   <= '0;
          state_q <= STROBE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_last_o  = rsp_last_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed self-checking bench for wb_initiator with a registered-ack responder
module tb_wb_initiator;
  logic        clk = 0, rst_n = 0;
  logic        cmd_valid = 0, cmd_we = 0, rsp_ready = 1;
  logic [31:0] cmd_adr = 0, cmd_dat = 0, rd_base = 0;
  logic [3:0]  cmd_sel = 0, cmd_len = 0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_last, wb_we, wb_cyc, wb_stb, wb_ack, busy, ack_en = 1;
  logic [31:0] rsp_dat, wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  int checks = 0, errors = 0;
  logic [31:0] w_adr[64], w_dat[64], r_dat[64];
  logic [3:0]  w_sel[64];
  logic        r_last[64], r_err[64];
  int ack_t[64];
  int w_n = 0, r_n = 0, cyc_ctr = 0, stb_rises = 0, cyc_falls = 0;
  logic stb_prev = 0, cyc_prev = 0;
  always #5 clk = ~clk;
  assign wb_dat_i = rd_base ^ wb_adr;
  wb_initiator #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_reset_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .cmd_we_i(cmd_we), .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .rsp_last_o(rsp_last),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .busy_o(busy)
  );
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wb_ack <= 1'b0;
    else wb_ack <= ack_en && wb_stb && wb_cyc && !wb_ack;
  always @(posedge clk) begin
    cyc_ctr  <= cyc_ctr + 1;
    stb_prev <= wb_stb;
    cyc_prev <= wb_cyc;
    if (wb_stb && !stb_prev) stb_rises <= stb_rises + 1;
    if (!wb_cyc && cyc_prev) cyc_falls <= cyc_falls + 1;
    if (wb_stb && wb_ack && w_n < 64) begin
      w_adr[w_n] <= wb_adr; w_dat[w_n] <= wb_dat_o; w_sel[w_n] <= wb_sel; ack_t[w_n] <= cyc_ctr;
      w_n <= w_n + 1;
    end
    if (rsp_valid && rsp_ready && r_n < 64) begin
      r_dat[r_n] <= rsp_dat; r_last[r_n] <= rsp_last; r_err[r_n] <= rsp_err;
      r_n <= r_n + 1;
    end
  end
  task automatic send_cmd(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                          input logic [3:0] sel, input logic [3:0] len);
    int n = 0;
    @(negedge clk);
    cmd_adr = adr; cmd_dat = dat; cmd_we = we; cmd_sel = sel; cmd_len = len; cmd_valid = 1;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin errors++; $display("FAIL cmd_accept: cmd_ready stuck low after %0d cycles, expected 1", n); end
    @(posedge clk); #1 cmd_valid = 0;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
  endtask
  task automatic test_reset;
    rst_n = 0; repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, wb_cyc, wb_stb, rsp_valid, busy, wb_we} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 100000", {cmd_ready, wb_cyc, wb_stb, rsp_valid, busy, wb_we});
    end
    checks++;
    if ({wb_adr, wb_dat_o, rsp_dat} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {wb_adr, wb_dat_o, rsp_dat}); end
    rst_n = 1; @(negedge clk);
  endtask
  task automatic test_single_read;
    int n;
    rd_base = 32'h0000_01AB; rsp_ready = 1;
    send_cmd(32'h100, 32'h0, 0, 4'hF, 4'd0);
    @(negedge clk);
    checks++;
    if ({wb_cyc, wb_stb, wb_we, busy, cmd_ready} !== 5'b11010) begin errors++; $display("FAIL rd_strobe: got %b expected 11010", {wb_cyc, wb_stb, wb_we, busy, cmd_ready}); end
    checks++;
    if (wb_adr !== 32'h100) begin errors++; $display("FAIL rd_adr_t1: got %h expected 00000100", wb_adr); end
    @(negedge clk);
    checks++;
    if (wb_stb !== 1'b1 || wb_adr !== 32'h100) begin errors++; $display("FAIL rd_adr_t2: stb %b adr %h expected 1 00000100", wb_stb, wb_adr); end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_last, wb_stb, wb_cyc} !== 5'b10100) begin errors++; $display("FAIL rd_rsp_flags: got %b expected 10100", {rsp_valid, rsp_err, rsp_last, wb_stb, wb_cyc}); end
    checks++;
    if (rsp_dat !== 32'h0000_00AB) begin errors++; $display("FAIL rd_rsp_dat: got %h expected 000000ab", rsp_dat); end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin errors++; $display("FAIL rd_done: got %b expected 010", {rsp_valid, cmd_ready, busy}); end
    send_cmd(32'h200, 32'h0, 0, 4'hF, 4'd0);
    wait_rsp(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL rd_latency: got %0d cycles expected 3", n); end
    wait_idle(n);
  endtask
  task automatic test_write_burst;
    int wb0, rb0, sr0, cf0, n;
    wb0 = w_n; rb0 = r_n; sr0 = stb_rises; cf0 = cyc_falls; rsp_ready = 1;
    send_cmd(32'h0, 32'h55, 1, 4'h1, 4'd2);
    wait_idle(n);
    @(negedge clk);
    checks++;
    if (w_n - wb0 !== 3) begin errors++; $display("FAIL wr_beats: got %0d expected 3", w_n - wb0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_adr[wb0+i] !== 32'(i) || w_dat[wb0+i] !== 32'h55 || w_sel[wb0+i] !== 4'h1) begin
        errors++; $display("FAIL wr_beat%0d: adr %h dat %h sel %h expected %h 00000055 1", i, w_adr[wb0+i], w_dat[wb0+i], w_sel[wb0+i], i);
      end
      checks++;
      if (r_last[rb0+i] !== (i == 2) || r_err[rb0+i] !== 1'b0 || r_dat[rb0+i] !== 32'h0) begin
        errors++; $display("FAIL wr_rsp%0d: last %b err %b dat %h expected %b 0 0", i, r_last[rb0+i], r_err[rb0+i], r_dat[rb0+i], i == 2);
      end
    end
    checks++;
    if (ack_t[wb0+1] - ack_t[wb0] !== 4 || ack_t[wb0+2] - ack_t[wb0+1] !== 4) begin
      errors++; $display("FAIL wr_spacing: got %0d %0d expected 4 4", ack_t[wb0+1] - ack_t[wb0], ack_t[wb0+2] - ack_t[wb0+1]);
    end
    checks++;
    if (stb_rises - sr0 !== 3 || cyc_falls - cf0 !== 1) begin
      errors++; $display("FAIL wr_stb_cyc: stb rises %0d cyc falls %0d expected 3 1", stb_rises - sr0, cyc_falls - cf0);
    end
  endtask
  task automatic test_timeout;
    int n;
    ack_en = 0; rsp_ready = 0;
    send_cmd(32'h20, 32'h0, 0, 4'hF, 4'd3);
    wait_rsp(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL tmo_latency: got %0d cycles from accept expected 10", n); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_last, wb_cyc, wb_stb} !== 5'b11100 || rsp_dat !== 32'h0) begin
      errors++; $display("FAIL tmo_rsp: flags %b dat %h expected 11100 0", {rsp_valid, rsp_err, rsp_last, wb_cyc, wb_stb}, rsp_dat);
    end
    rsp_ready = 1; ack_en = 1;
    wait_idle(n);
    rd_base = 32'h1234_0000;
    send_cmd(32'h21, 32'h0, 0, 4'hF, 4'd0);
    wait_rsp(n);
    checks++;
    if (n !== 3 || rsp_err !== 1'b0 || rsp_dat !== 32'h1234_0021) begin
      errors++; $display("FAIL tmo_recover: cycles %0d err %b dat %h expected 3 0 12340021", n, rsp_err, rsp_dat);
    end
    wait_idle(n);
  endtask
  task automatic test_stall;
    int n, sr0, rb0;
    logic ok;
    rd_base = 32'h1000; rsp_ready = 0; rb0 = r_n;
    send_cmd(32'h40, 32'h0, 0, 4'hF, 4'd2);
    wait_rsp(n);
    sr0 = stb_rises; ok = 1;
    repeat (10) begin
      @(negedge clk);
      if ({wb_cyc, wb_stb, rsp_valid, rsp_last} !== 4'b1010 || rsp_dat !== 32'h1040) ok = 0;
    end
    checks++;
    if (!ok || stb_rises !== sr0) begin errors++; $display("FAIL stall_hold: ok %b new stb rises %0d expected 1 0", ok, stb_rises - sr0); end
    rsp_ready = 1;
    wait_idle(n);
    @(negedge clk);
    checks++;
    if (r_n - rb0 !== 3 || r_dat[rb0] !== 32'h1040 || r_dat[rb0+1] !== 32'h1041 || r_dat[rb0+2] !== 32'h1042) begin
      errors++; $display("FAIL stall_resume: n %0d dat %h %h %h expected 3 1040 1041 1042", r_n - rb0, r_dat[rb0], r_dat[rb0+1], r_dat[rb0+2]);
    end
    checks++;
    if ({r_last[rb0], r_last[rb0+1], r_last[rb0+2]} !== 3'b001) begin
      errors++; $display("FAIL stall_last: got %b expected 001", {r_last[rb0], r_last[rb0+1], r_last[rb0+2]});
    end
  endtask
  task automatic test_wrap;
    int n, wb0;
    wb0 = w_n; rsp_ready = 1;
    send_cmd(32'hFFFF_FFFF, 32'hA5A5_0001, 1, 4'hC, 4'd1);
    wait_idle(n);
    @(negedge clk);
    checks++;
    if (w_n - wb0 !== 2 || w_adr[wb0] !== 32'hFFFF_FFFF || w_adr[wb0+1] !== 32'h0) begin
      errors++; $display("FAIL wrap_adr: n %0d adr %h %h expected 2 ffffffff 00000000", w_n - wb0, w_adr[wb0], w_adr[wb0+1]);
    end
  endtask
  task automatic test_async_reset;
    ack_en = 0;
    send_cmd(32'h300, 32'h0, 0, 4'hF, 4'd0);
    @(negedge clk);
    checks++;
    if ({wb_cyc, wb_stb} !== 2'b11) begin errors++; $display("FAIL arst_pre: got %b expected 11", {wb_cyc, wb_stb}); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, rsp_valid, busy} !== 4'b0000) begin errors++; $display("FAIL arst_drop: got %b expected 0000", {wb_cyc, wb_stb, rsp_valid, busy}); end
    @(negedge clk); rst_n = 1; ack_en = 1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, wb_cyc, wb_stb, rsp_valid} !== 4'b1000) begin errors++; $display("FAIL arst_release: got %b expected 1000", {cmd_ready, wb_cyc, wb_stb, rsp_valid}); end
  endtask
  initial begin
    test_reset;
    test_single_read;
    test_write_burst;
    test_timeout;
    test_stall;
    test_wrap;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic-cycle initiator converting a simple command stream (valid/ready) into single or auto-incrementing burst bus accesses against the register-mapped peripherals on the fabric. It sits between a control source (debug bridge, sequencer, test harness) and the Wishbone interconnect. It returns one response per bus beat and aborts stalled cycles with a timeout error, so an unresponsive responder never hangs the control source.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- TIMEOUT, 255, cycles to wait for ack per beat before abort (1..65535)

Ports:
- wb_clk_i  in  1  clock
- wb_reset_n_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_adr_i  in  AW  start word address
- cmd_dat_i  in  DW  write data (every beat of a write burst uses it, fill semantics)
- cmd_we_i  in  1  1=write, 0=read
- cmd_sel_i  in  DW/8  byte selects, constant across the burst
- cmd_len_i  in  4  beats minus one (0 = single access, 15 = 16 beats)
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_dat_o  out  DW  read data (0 for writes and errors)
- rsp_err_o  out  1  beat timed out
- rsp_last_o  out  1  final response of the command
- wb_adr_o, wb_dat_o  out  AW, DW  bus address / write data
- wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  bus controls
- wb_sel_o  out  DW/8  byte selects
- wb_dat_i  in  DW  bus read data
- wb_ack_i  in  1  bus acknowledge
- busy_o  out  1  high from command accept until last response consumed

## Operation
- Reset: all outputs 0 except cmd_ready_o=1; FSM in IDLE; counters 0.
- FSM states: IDLE, STROBE, GAP, RESP.
- IDLE: cmd_ready_o=1. On accept, latch adr/dat/we/sel, beat counter=cmd_len_i, go STROBE.
- STROBE: cyc=stb=1, adr/dat/we/sel driven from latched values. Timeout counter increments each cycle.
  - ack sampled high: capture wb_dat_i (reads), drop stb; go RESP.
  - counter reaches TIMEOUT without ack: drop cyc and stb, set err, last=1, go RESP.
- RESP: rsp_valid_o=1, cyc held high unless error or final beat. On rsp handshake: if final or err -> IDLE (cyc=0); else address+1, counter-1, go GAP.
- GAP: one cycle, cyc=1, stb=0; then STROBE. Guarantees stb low between beats so registered-ack responders re-arm.
- Address increments by 1 per beat, wrapping modulo 2^AW.
- ack arriving while stb=0 (GAP, RESP, IDLE) is ignored.
- ack on the same edge as the timeout: ack wins, no error.
- Only one response outstanding; the next beat is not issued until the previous response is consumed (rsp_ready_i low stalls the burst with cyc held high, stb low).

## Timing
- Command accepted at edge T: stb/cyc high from T (registered, visible cycle T+1).
- Zero-wait responder (ack registered one cycle after stb): ack sampled at T+2, rsp_valid_o high cycle after T+2, stb low that same cycle.
- Single access, rsp_ready_i=1: 3 cycles accept-to-response, cmd_ready_o high again cycle after response handshake.
- Burst beat spacing with rsp_ready_i=1 and zero-wait responder: 4 cycles (STROBE 2, RESP 1, GAP 1).
- Timeout error response appears TIMEOUT+1 cycles after stb rise.
- Reset assertion mid-cycle: cyc/stb drop asynchronously, pending response discarded.

## Structure
- Package wb_initiator_pkg: FSM state enum, LEN_W=4 constant.
- No sub-module; timeout counter and beat counter inline. Counter width $clog2(TIMEOUT+1).

## Test plan
- Single read, responder returns 0x000000AB one cycle after stb -> one response dat=0xAB, err=0, last=1, wb_adr_o held at command address while stb high.
- Write burst len=2 to 0x0, dat=0x55, sel=4'h1 -> three writes at 0x0,0x1,0x2 all data 0x55, stb low one cycle between beats, cyc continuous, last=1 only on third response.
- Responder never acks, TIMEOUT=8 -> err=1, dat=0, last=1 nine cycles after stb; cyc/stb low; following command works normally.
- rsp_ready_i held low 10 cycles mid-burst -> no new stb during stall, cyc stays high, response data stable, burst resumes after handshake.
- Burst starting at address 0xFFFFFFFF, len=1 -> second beat at 0x00000000.
- Async reset asserted during STROBE -> cyc/stb/rsp_valid drop immediately, cmd_ready_o=1 after release.
